// File: rtl/ws_color_if.sv
// Host/sender bundle for ws_color_ctrl.
// master = host side (drives writes, commit, brightness, chase request).
// slave  = ws_color_ctrl (drives the active colour array and status).
// Handshake: a shadow write is taken on a clock edge where wr_en && wr_ready;
// with wr_ready low the write is dropped; there is no back-pressure queue.
interface ws_color_if #(
  parameter int DEPTH  = 24,
  parameter int WS_NUM = 7
);
  logic             wr_en;
  logic [7:0]       wr_addr;
  logic [DEPTH-1:0] wr_data;
  logic             wr_ready;
  logic             commit;
  logic [7:0]       bright;
  logic             chase_en;
  logic [DEPTH-1:0] wscolor [WS_NUM];
  logic             busy;
  logic             frame_done;
  logic             err_addr;

  modport master (
    output wr_en, wr_addr, wr_data, commit, bright, chase_en,
    input  wr_ready, wscolor, busy, frame_done, err_addr
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, bright, chase_en,
    output wr_ready, wscolor, busy, frame_done, err_addr
  );
endinterface

// File: rtl/ws_color_ctrl.sv
// ws_color_ctrl: shadow/active colour buffer feeding the WS2812 sender.
// Host writes land in the shadow buffer; a commit is published on the next
// refresh tick by copying one LED per cycle, scaled by the brightness latched
// at launch, so the active buffer never shows a half-written frame.
// Optional feature macro: WS_CHASE_EN (test-chase pattern generator).
// dbg_state: 1 while the FSM is in COPY, 0 in IDLE.
module ws_color_ctrl #(
  parameter int          DEPTH      = 24,
  parameter int unsigned CLKHZ      = 32'd50_000_000,
  parameter int          WS_NUM     = 7,
  parameter int unsigned REFRESH_HZ = 32'd100
) (
  input  logic       clk,
  input  logic       rst,
  ws_color_if.slave  bus,
  output logic       dbg_state
);
  localparam int unsigned TICK_CYCLES = CLKHZ / REFRESH_HZ;
  localparam int          IDX_W       = (WS_NUM > 1) ? $clog2(WS_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WS_NUM - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_COPY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic [7:0]       bright_q, bright_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [DEPTH-1:0] shadow_q  [WS_NUM];
  logic [DEPTH-1:0] shadow_d  [WS_NUM];
  logic [DEPTH-1:0] wscolor_q [WS_NUM];
  logic [DEPTH-1:0] wscolor_d [WS_NUM];

  logic             tick;
  logic             in_range;
  logic             wr_ok;
  logic [DEPTH-1:0] src;

`ifdef WS_CHASE_EN
  logic             chase_q, chase_d;
  logic [IDX_W-1:0] chase_pos_q, chase_pos_d;
`else
  logic unused_chase_en;
  assign unused_chase_en = bus.chase_en;
`endif

  // One channel: (ch * (b + 1)) >> 8 in a 17-bit product, truncating.
  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] b);
    logic [16:0] prod;
    prod = {9'd0, ch} * ({9'd0, b} + 17'd1);
    return 8'(prod >> 8);
  endfunction

  // RGB888 pixel scaled channel by channel.
  function automatic logic [DEPTH-1:0] scale_px(input logic [DEPTH-1:0] p, input logic [7:0] b);
    return {scale_ch(p[23:16], b), scale_ch(p[15:8], b), scale_ch(p[7:0], b)};
  endfunction

  // Next-state logic: tick counter, shadow writes, pending, copy FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    bright_d  = bright_q;
    done_d    = 1'b0;
    err_d     = err_q;
    shadow_d  = shadow_q;
    wscolor_d = wscolor_q;
`ifdef WS_CHASE_EN
    chase_d     = chase_q;
    chase_pos_d = chase_pos_q;
`endif

    tick  = (cnt_q == TICK_CYCLES - 1);
    cnt_d = tick ? 32'd0 : cnt_q + 32'd1;

    // Writes are only taken in IDLE; out-of-range taken writes raise the sticky flag.
    in_range = ({24'd0, bus.wr_addr} < 32'(WS_NUM));
    wr_ok    = bus.wr_en && (state_q == S_IDLE);
    if (wr_ok) begin
      if (in_range) shadow_d[bus.wr_addr[IDX_W-1:0]] = bus.wr_data;
      else          err_d = 1'b1;
    end

`ifdef WS_CHASE_EN
    src = chase_q ? ((idx_q == chase_pos_q) ? {DEPTH{1'b1}} : {DEPTH{1'b0}})
                  : shadow_q[idx_q];
`else
    src = shadow_q[idx_q];
`endif

    case (state_q)
      S_IDLE: begin
`ifdef WS_CHASE_EN
        if (tick && bus.chase_en) begin
          // Chase frames leave pending untouched for later.
          state_d  = S_COPY;
          idx_d    = '0;
          bright_d = bus.bright;
          chase_d  = 1'b1;
        end else if (tick && pending_q) begin
          state_d   = S_COPY;
          idx_d     = '0;
          bright_d  = bus.bright;
          pending_d = 1'b0;
          chase_d   = 1'b0;
        end
`else
        if (tick && pending_q) begin
          state_d   = S_COPY;
          idx_d     = '0;
          bright_d  = bus.bright;
          pending_d = 1'b0;
        end
`endif
      end
      S_COPY: begin
        wscolor_d[idx_q] = scale_px(src, bright_q);
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
`ifdef WS_CHASE_EN
          if (chase_q) chase_pos_d = (chase_pos_q == LAST_IDX) ? '0 : chase_pos_q + 1'b1;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A commit always (re)arms pending, including during COPY or on a launch edge.
    if (bus.commit) pending_d = 1'b1;
  end

  // State registers with synchronous reset; reset also blanks the active buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      bright_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < WS_NUM; i++) begin
        shadow_q[i]  <= '0;
        wscolor_q[i] <= '0;
      end
`ifdef WS_CHASE_EN
      chase_q     <= 1'b0;
      chase_pos_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      bright_q  <= bright_d;
      done_q    <= done_d;
      err_q     <= err_d;
      shadow_q  <= shadow_d;
      wscolor_q <= wscolor_d;
`ifdef WS_CHASE_EN
      chase_q     <= chase_d;
      chase_pos_q <= chase_pos_d;
`endif
    end
  end

  assign bus.wscolor    = wscolor_q;
  assign bus.wr_ready   = (state_q == S_IDLE);
  assign bus.busy       = pending_q || (state_q == S_COPY);
  assign bus.frame_done = done_q;
  assign bus.err_addr   = err_q;
  assign dbg_state      = (state_q == S_COPY);
endmodule

// File: tb/tb_ws_color_ctrl.sv
// Bench for ws_color_ctrl at CLKHZ=1000, REFRESH_HZ=100 (tick every 10 cycles), WS_NUM=7.
module tb_ws_color_ctrl;
  localparam int DEPTH  = 24;
  localparam int WS_NUM = 7;
  localparam int TICK   = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;
  always #5 clk = ~clk;

  ws_color_if #(.DEPTH(DEPTH), .WS_NUM(WS_NUM)) bus ();

  ws_color_ctrl #(
    .DEPTH(DEPTH), .CLKHZ(32'd1000), .WS_NUM(WS_NUM), .REFRESH_HZ(32'd100)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;
  int frames_seen = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  int         m_cnt, m_cyc, m_launch, m_chase_pos;
  bit         m_pending, m_err, m_done, m_chase_frame;
  logic [23:0] m_shadow [WS_NUM];
  logic [23:0] m_active [WS_NUM];
  logic [23:0] m_frame  [WS_NUM];

  function automatic logic [23:0] m_scale(input logic [23:0] p, input int b);
    int r, g, bl;
    r  = (int'(p[23:16]) * (b + 1)) / 256;
    g  = (int'(p[15:8])  * (b + 1)) / 256;
    bl = (int'(p[7:0])   * (b + 1)) / 256;
    return {r[7:0], g[7:0], bl[7:0]};
  endfunction

  // Copy occupies the WS_NUM cycles right after the launch cycle.
  function automatic bit m_copying(input int c);
    return (m_launch >= 0) && (c >= m_launch + 1) && (c <= m_launch + WS_NUM);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_cyc = 0; m_launch = -1; m_chase_pos = 0;
      m_pending = 0; m_err = 0; m_done = 0; m_chase_frame = 0;
      for (int i = 0; i < WS_NUM; i++) begin
        m_shadow[i] = '0; m_active[i] = '0; m_frame[i] = '0;
      end
    end else begin
      automatic int c  = m_cyc;
      automatic bit cp = m_copying(c);
      if (bus.wr_en && !cp) begin
        if (bus.wr_addr < WS_NUM) m_shadow[bus.wr_addr] = bus.wr_data;
        else m_err = 1;
      end
      if (cp) m_active[c - m_launch - 1] = m_frame[c - m_launch - 1];
      m_done = cp && (c == m_launch + WS_NUM);
      if (m_done && m_chase_frame) m_chase_pos = (m_chase_pos + 1) % WS_NUM;
      if (!cp && m_cnt == TICK - 1) begin
`ifdef WS_CHASE_EN
        if (bus.chase_en) begin
          m_launch = c; m_chase_frame = 1;
          for (int i = 0; i < WS_NUM; i++)
            m_frame[i] = (i == m_chase_pos) ? m_scale(24'hFFFFFF, int'(bus.bright)) : 24'h0;
        end else
`endif
        if (m_pending) begin
          m_launch = c; m_chase_frame = 0; m_pending = 0;
          for (int i = 0; i < WS_NUM; i++) m_frame[i] = m_scale(m_shadow[i], int'(bus.bright));
        end
      end
      if (bus.commit) m_pending = 1;
      m_cnt = (m_cnt == TICK - 1) ? 0 : m_cnt + 1;
      m_cyc++;
    end
  end

  // ---------------- scoreboard compare (every cycle, on negedge) ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < WS_NUM; i++)
        chk($sformatf("wscolor[%0d]", i), 32'(bus.wscolor[i]), 32'(m_active[i]));
      chk("busy", 32'(bus.busy), 32'(m_pending || m_copying(m_cyc)));
      chk("wr_ready", 32'(bus.wr_ready), 32'(!m_copying(m_cyc)));
      chk("frame_done", 32'(bus.frame_done), 32'(m_done));
      chk("err_addr", 32'(bus.err_addr), 32'(m_err));
      chk("dbg_state", 32'(dbg_state), 32'(m_copying(m_cyc)));
      if (bus.frame_done) frames_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [23:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic do_commit();
    @(negedge clk);
    bus.commit = 1'b1;
    @(negedge clk);
    bus.commit = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.frame_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!bus.frame_done) fail_now("frame_done_timeout");
  endtask

  task automatic wait_copy(input int budget);
    int k;
    k = 0;
    while (!dbg_state && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!dbg_state) fail_now("copy_start_timeout");
  endtask

  task automatic wait_cnt(input int v, input int budget);
    int k;
    k = 0;
    while (m_cnt != v && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (m_cnt != v) fail_now("tick_phase_timeout");
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int f0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.commit = 1'b0; bus.bright = 8'd255; bus.chase_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    // Reset then idle: nothing happens without a commit.
    idle(25);
    chk("idle_frames", 32'(frames_seen), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < WS_NUM; i++) chk("idle_black", 32'(bus.wscolor[i]), 32'd0);

    // Basic publish at full brightness, with latency pinned to the tick phase.
    bus.bright = 8'd255;
    wr(8'd0, 24'h123456);
    wr(8'd6, 24'hFF8000);
    do_commit();
    chk("busy_after_commit", 32'(bus.busy), 32'd1);
    wait_done(40);
    chk("done_phase", 32'(m_cnt), 32'd7);
    chk("lit_w0", 32'(bus.wscolor[0]), 32'h123456);
    chk("lit_w6", 32'(bus.wscolor[6]), 32'hFF8000);

    // Half and zero brightness.
    bus.bright = 8'd127;
    wr(8'd2, 24'hFFFFFF);
    do_commit();
    wait_done(40);
    chk("lit_b127_w2", 32'(bus.wscolor[2]), 32'h7F7F7F);
    chk("lit_b127_w0", 32'(bus.wscolor[0]), 32'h091A2B);
    chk("lit_b127_w6", 32'(bus.wscolor[6]), 32'h7F4000);
    bus.bright = 8'd0;
    do_commit();
    wait_done(40);
    chk("lit_b0_w2", 32'(bus.wscolor[2]), 32'h000000);
    chk("lit_b0_w6", 32'(bus.wscolor[6]), 32'h000000);

    // Writes during COPY are dropped silently, even out-of-range ones.
    bus.bright = 8'd255;
    do_commit();
    wait_copy(30);
    chk("wr_ready_in_copy", 32'(bus.wr_ready), 32'd0);
    bus.wr_en = 1'b1; bus.wr_addr = 8'd9; bus.wr_data = 24'h555555;
    @(negedge clk);
    bus.wr_addr = 8'd1; bus.wr_data = 24'hAAAAAA;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("err_after_copy_wr", 32'(bus.err_addr), 32'd0);
    wait_done(40);
    wr(8'd7, 24'h123123);
    chk("err_out_of_range", 32'(bus.err_addr), 32'd1);
    do_commit();
    wait_done(40);
    chk("lit_dropped_w1", 32'(bus.wscolor[1]), 32'h000000);
    chk("lit_full_w2", 32'(bus.wscolor[2]), 32'hFFFFFF);
    chk("err_sticky", 32'(bus.err_addr), 32'd1);

    // Two commits before one tick collapse into one frame.
    wait_cnt(0, 20);
    f0 = frames_seen;
    do_commit();
    do_commit();
    wait_done(40);
    idle(30);
    chk("collapse_frames", 32'(frames_seen - f0), 32'd1);

    // A commit during COPY produces a second frame on the next tick.
    f0 = frames_seen;
    do_commit();
    wait_copy(30);
    bus.commit = 1'b1;
    @(negedge clk);
    bus.commit = 1'b0;
    wait_done(40);
    wait_done(40);
    idle(30);
    chk("rearm_frames", 32'(frames_seen - f0), 32'd2);

    // Reset in the 4th COPY cycle blanks the strip and suppresses frame_done.
    do_commit();
    wait_copy(30);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    f0 = frames_seen;
    for (int i = 0; i < WS_NUM; i++) chk("rst_black", 32'(bus.wscolor[i]), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_err", 32'(bus.err_addr), 32'd0);
    idle(25);
    chk("rst_no_frame", 32'(frames_seen - f0), 32'd0);

`ifdef WS_CHASE_EN
    // Chase: one white LED walking through the chain, one step per frame.
    bus.bright = 8'd255;
    bus.chase_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      wait_done(40);
      for (int i = 0; i < WS_NUM; i++)
        chk($sformatf("chase_f%0d_w%0d", k, i), 32'(bus.wscolor[i]),
            (i == k % WS_NUM) ? 32'hFFFFFF : 32'h0);
    end
    bus.chase_en = 1'b0;
    idle(20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ws_color_ctrl.md
Name: ws_color_ctrl

Overview:
- Upstream feeder for the WS2812 serial sender.
- Holds a host-writable shadow colour buffer and an active buffer; the active buffer drives the sender's per-LED RGB888 colour array.
- Host commits are applied only on an internal refresh tick. The copy applies global brightness scaling, one LED per cycle, so the strip never shows a half-written frame.

Parameters:
- DEPTH, 24, colour width per LED (RGB888, R in [23:16], G in [15:8], B in [7:0]).
- CLKHZ, 32'd50_000_000, clock frequency in Hz.
- WS_NUM, 7, number of LEDs in the chain.
- REFRESH_HZ, 32'd100, commit/refresh tick rate; TICK_CYCLES = CLKHZ/REFRESH_HZ (integer division).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  host write strobe for the shadow buffer.
- wr_addr  input  8  LED index to write.
- wr_data  input  DEPTH  RGB888 colour for the shadow buffer.
- wr_ready  output  1  high when shadow writes are accepted.
- commit  input  1  single-cycle request to publish the shadow buffer.
- bright  input  8  global brightness.
- chase_en  input  1  test-chase mode request; ignored unless WS_CHASE_EN is defined.
- wscolor  output  DEPTH x WS_NUM (unpacked [WS_NUM])  active colours to the sender.
- busy  output  1  pending or copy in progress.
- frame_done  output  1  one-cycle pulse after the active buffer is fully updated.
- err_addr  output  1  sticky out-of-range write flag.

Behaviour:
- Reset: shadow and all wscolor entries = 0, tick counter = 0, state IDLE, pending = 0, busy = 0, frame_done = 0, err_addr = 0, wr_ready = 1.
- Tick: counter runs 0..TICK_CYCLES-1 and wraps. tick = 1 for exactly one cycle, when the counter equals TICK_CYCLES-1.
- Shadow write: on a cycle with wr_en && wr_ready && wr_addr < WS_NUM, shadow[wr_addr] <= wr_data.
  - wr_en with wr_addr >= WS_NUM: write dropped, err_addr <= 1 (held until rst).
  - wr_en while wr_ready = 0: write dropped silently, no error.
- commit sets pending at the clock edge. commit during COPY re-arms pending for the next tick. Multiple commits before a tick collapse into one.
- FSM states: IDLE, COPY.
  - IDLE -> COPY on a tick cycle when pending = 1. pending clears, idx <= 0, and bright is latched into bright_l.
  - COPY lasts exactly WS_NUM cycles. Each cycle: wscolor[idx] <= scale(shadow[idx]), idx++.
  - After the cycle with idx = WS_NUM-1: go to IDLE; frame_done = 1 for the next cycle only.
  - A tick arriving during COPY is ignored for launch. pending persists until a tick seen in IDLE.
- wr_ready = (state == IDLE). busy = pending || (state == COPY).
- Scaling, per 8-bit channel: out = (ch * (bright_l + 1)) >> 8, using a 17-bit intermediate.
  - bright = 255 gives identity; bright = 0 gives 0. No rounding.
- Latency: tick cycle T with pending -> wscolor[0] updates at edge T+2, wscolor[WS_NUM-1] at edge T+1+WS_NUM, frame_done high in the following cycle.
- Simultaneous events:
  - commit in the same cycle as a tick in IDLE with pending = 0: no launch this tick; pending set for the next tick.
  - wr_en and commit in the same IDLE cycle: the write lands first and is included in the commit.
- rst mid-COPY: immediate return to reset values. The active buffer is cleared, so the sender emits black.

Optional Feature:
- Macro: WS_CHASE_EN.
- Defined:
  - Adds a chase_pos register (0..WS_NUM-1, reset 0).
  - When chase_en = 1, every tick in IDLE launches COPY with source pattern: LED chase_pos = 24'hFFFFFF, all other LEDs = 0. The pattern is scaled by bright_l.
  - chase_pos increments modulo WS_NUM after each chase frame.
  - pending is neither consumed nor cleared while chase_en = 1.
  - The shadow buffer stays writable in IDLE.
- Undefined:
  - chase_en has no effect; no chase_pos logic is generated.

Test Plan:
- Reset then idle (CLKHZ=1000, REFRESH_HZ=100, WS_NUM=7): all wscolor = 0, busy = 0, tick every 10 cycles, no frame_done.
- Write shadow[0] = 24'h123456 and shadow[6] = 24'hFF8000, bright = 255, commit -> busy = 1 until the next tick. wscolor[0] = 24'h123456 and wscolor[6] = 24'hFF8000 after 7 copy cycles. frame_done pulses once, 8 cycles after the tick.
- bright = 127, shadow[2] = 24'hFFFFFF, commit -> wscolor[2] = 24'h7F7F7F. Repeat with bright = 0 -> 24'h000000.
- wr_en with wr_addr = 7 -> no shadow change, err_addr = 1 until rst. wr_en during COPY -> wr_ready = 0, write dropped, err_addr unchanged.
- Two commits before a tick -> one COPY only. commit asserted during COPY -> a second COPY on the following tick.
- rst asserted at the 4th COPY cycle -> next cycle all wscolor = 0, state IDLE, no frame_done. With WS_CHASE_EN, chase_en = 1, bright = 255 -> wscolor[k] = 24'hFFFFFF on frame k mod 7, all other LEDs 0.
